// File: rtl/bcd_stream_decoder.sv
// ---------------------------------------------------------------------------
// bcd_stream_decoder
//
// Purpose:
//   Receives 4-bit BCD digits over a valid/ready handshake and decodes each
//   one into a 10-bit one-hot vector. DIGITS decoded digits are gathered into
//   one frame, which is offered on a valid/ready output port. Codes 10..15
//   decode to all-zero, are flagged per digit in dig_err, and are counted in
//   a saturating counter.
//
// Parameters:
//   DIGITS     digits per output frame (1..8)
//   CNT_W      width of the invalid-digit counter
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   A          BCD digit, sampled when in_valid && in_ready
//   in_valid   A holds a digit
//   in_ready   block can accept a digit this cycle
//   D          decoded frame, digit k in D[10k+9:10k], digit 0 received first
//   dig_err    bit k set when digit k of the frame was an invalid code
//   out_valid  D/dig_err hold a complete frame
//   out_ready  consumer takes the frame
//   err_count  saturating count of invalid digits accepted since reset
// ---------------------------------------------------------------------------
module bcd_stream_decoder #(
    parameter int DIGITS = 4,
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             A,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [10*DIGITS-1:0]   D,
    output logic [DIGITS-1:0]      dig_err,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       err_count
);

    // A one-digit frame still needs a 1-bit index so the port widths stay legal.
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t                 state;
    logic [10*DIGITS-1:0]   buf_d;
    logic [DIGITS-1:0]      buf_e;
    logic [IDX_W-1:0]       idx;

    logic [9:0]             dec_onehot;
    logic                   dec_err;
    logic                   accept;
    logic                   last_digit;
    logic [10*DIGITS-1:0]   frame_d;
    logic [DIGITS-1:0]      frame_e;

    // The input side opens whenever no frame is waiting or the waiting frame
    // leaves this cycle, so a new frame can start with no bubble.
    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign last_digit = (idx == LAST_IDX);

    // Digit decode: one-hot for 0..9, all-zero plus error flag for 10..15.
    always_comb begin
        dec_onehot = '0;
        dec_err    = 1'b0;
        if (A <= 4'd9) begin
            dec_onehot = 10'd1 << A;
        end else begin
            dec_err = 1'b1;
        end
    end

    // The collect buffer with the incoming digit merged into slot idx. This is
    // both the next buffer contents and, on the last digit, the completed frame.
    always_comb begin
        frame_d = buf_d;
        frame_e = buf_e;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                frame_d[10*k +: 10] = dec_onehot;
                frame_e[k]          = dec_err;
            end
        end
    end

    // Datapath and control. A completed frame moves to D/dig_err on the edge
    // that accepts its last digit; D/dig_err otherwise hold the previous frame
    // even after it has been consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            out_valid <= 1'b0;
            D         <= '0;
            dig_err   <= '0;
            buf_d     <= '0;
            buf_e     <= '0;
            idx       <= '0;
            err_count <= '0;
        end else begin
            if (accept) begin
                if (last_digit) begin
                    D       <= frame_d;
                    dig_err <= frame_e;
                    buf_d   <= '0;
                    buf_e   <= '0;
                    idx     <= '0;
                end else begin
                    buf_d <= frame_d;
                    buf_e <= frame_e;
                    idx   <= idx + 1'b1;
                end
                if (dec_err && (err_count != {CNT_W{1'b1}})) begin
                    err_count <= err_count + 1'b1;
                end
            end

            // A frame completing while the previous one is consumed (only
            // possible with one-digit frames) keeps the block in FULL.
            case (state)
                COLLECT: begin
                    if (accept && last_digit) begin
                        state     <= FULL;
                        out_valid <= 1'b1;
                    end
                end
                FULL: begin
                    if (accept && last_digit) begin
                        state     <= FULL;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        state     <= COLLECT;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= COLLECT;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_stream_decoder.sv
// ---------------------------------------------------------------------------
// tb_bcd_stream_decoder
//
// Directed bench for bcd_stream_decoder. Three instances share clk/rst:
//   u_d4 : DIGITS=4, CNT_W=8  (frames, errors, backpressure, reset mid-frame)
//   u_c2 : DIGITS=4, CNT_W=2  (counter saturation)
//   u_d1 : DIGITS=1, CNT_W=8  (back-to-back single-digit frames)
// Inputs change on the falling edge; outputs are checked on the falling edge
// following the rising edge that produced them.
// ---------------------------------------------------------------------------
module tb_bcd_stream_decoder;

    logic        clk;
    logic        rst;

    logic [3:0]  a4, ac, a1;
    logic        iv4, ivc, iv1;
    logic        or4, orc, or1;

    logic        ir4, irc, ir1;
    logic        ov4, ovc, ov1;
    logic [39:0] d4, dc;
    logic [9:0]  d1;
    logic [3:0]  e4, ec;
    logic [0:0]  e1;
    logic [7:0]  cnt4, cnt1;
    logic [1:0]  cntc;

    int total;
    int bad;

    bcd_stream_decoder #(.DIGITS(4), .CNT_W(8)) u_d4 (
        .clk(clk), .rst(rst), .A(a4), .in_valid(iv4), .in_ready(ir4),
        .D(d4), .dig_err(e4), .out_valid(ov4), .out_ready(or4),
        .err_count(cnt4)
    );

    bcd_stream_decoder #(.DIGITS(4), .CNT_W(2)) u_c2 (
        .clk(clk), .rst(rst), .A(ac), .in_valid(ivc), .in_ready(irc),
        .D(dc), .dig_err(ec), .out_valid(ovc), .out_ready(orc),
        .err_count(cntc)
    );

    bcd_stream_decoder #(.DIGITS(1), .CNT_W(8)) u_d1 (
        .clk(clk), .rst(rst), .A(a1), .in_valid(iv1), .in_ready(ir1),
        .D(d1), .dig_err(e1), .out_valid(ov1), .out_ready(or1),
        .err_count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus into the selected instance (0=u_d4,
    // 1=u_c2, 2=u_d1), keep the others idle, then land on the next falling edge.
    task automatic applyStimulus(input int sel, input logic [3:0] v,
                                 input logic valid, input logic ordy);
        iv4 = 1'b0; or4 = 1'b1;
        ivc = 1'b0; orc = 1'b1;
        iv1 = 1'b0; or1 = 1'b1;
        case (sel)
            0: begin a4 = v; iv4 = valid; or4 = ordy; end
            1: begin ac = v; ivc = valid; orc = ordy; end
            default: begin a1 = v; iv1 = valid; or1 = ordy; end
        endcase
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        a4 = 4'd0; ac = 4'd0; a1 = 4'd0;
        iv4 = 1'b0; ivc = 1'b0; iv1 = 1'b0;
        or4 = 1'b1; orc = 1'b1; or1 = 1'b1;

        // Reset values
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_in_ready",  64'(ir4),  64'd1);
        checkOutput("rst_out_valid", 64'(ov4),  64'd0);
        checkOutput("rst_D",         64'(d4),   64'd0);
        checkOutput("rst_dig_err",   64'(e4),   64'd0);
        checkOutput("rst_err_count", 64'(cnt4), 64'd0);

        // Stream 1,2,3,4 with the consumer ready
        applyStimulus(0, 4'd1, 1'b1, 1'b1);
        applyStimulus(0, 4'd2, 1'b1, 1'b1);
        applyStimulus(0, 4'd3, 1'b1, 1'b1);
        checkOutput("f1_not_yet_valid", 64'(ov4), 64'd0);
        applyStimulus(0, 4'd4, 1'b1, 1'b1);
        checkOutput("f1_out_valid", 64'(ov4), 64'd1);
        checkOutput("f1_D", 64'(d4), 64'({10'h010, 10'h008, 10'h004, 10'h002}));
        checkOutput("f1_dig_err", 64'(e4), 64'd0);
        applyStimulus(0, 4'd0, 1'b0, 1'b1);
        checkOutput("f1_consumed", 64'(ov4), 64'd0);
        checkOutput("f1_D_held", 64'(d4), 64'({10'h010, 10'h008, 10'h004, 10'h002}));

        // Stream 9,12,0,15 with two invalid codes
        applyStimulus(0, 4'd9,  1'b1, 1'b1);
        applyStimulus(0, 4'd12, 1'b1, 1'b1);
        checkOutput("f2_cnt_mid", 64'(cnt4), 64'd1);
        applyStimulus(0, 4'd0,  1'b1, 1'b1);
        applyStimulus(0, 4'd15, 1'b1, 1'b1);
        checkOutput("f2_out_valid", 64'(ov4), 64'd1);
        checkOutput("f2_D", 64'(d4), 64'({10'h000, 10'h001, 10'h000, 10'h200}));
        checkOutput("f2_dig_err", 64'(e4), 64'b1010);
        checkOutput("f2_err_count", 64'(cnt4), 64'd2);

        // Backpressure: invalid digit offered, must not be accepted
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 4'd11, 1'b1, 1'b0);
            checkOutput("bp_in_ready",  64'(ir4),  64'd0);
            checkOutput("bp_out_valid", 64'(ov4),  64'd1);
            checkOutput("bp_D", 64'(d4), 64'({10'h000, 10'h001, 10'h000, 10'h200}));
            checkOutput("bp_err_count", 64'(cnt4), 64'd2);
        end
        applyStimulus(0, 4'd5, 1'b1, 1'b1);
        checkOutput("bp_release_valid", 64'(ov4), 64'd0);
        checkOutput("bp_release_D", 64'(d4), 64'({10'h000, 10'h001, 10'h000, 10'h200}));
        applyStimulus(0, 4'd6, 1'b1, 1'b1);
        applyStimulus(0, 4'd8, 1'b1, 1'b1);
        applyStimulus(0, 4'd3, 1'b1, 1'b1);
        checkOutput("f3_out_valid", 64'(ov4), 64'd1);
        checkOutput("f3_D", 64'(d4), 64'({10'h008, 10'h100, 10'h040, 10'h020}));
        checkOutput("f3_dig_err", 64'(e4), 64'd0);

        // Reset mid-frame, with a digit presented during reset
        applyStimulus(0, 4'd13, 1'b1, 1'b1);
        checkOutput("pre_rst_cnt", 64'(cnt4), 64'd3);
        applyStimulus(0, 4'd2, 1'b1, 1'b1);
        rst = 1'b1;
        applyStimulus(0, 4'd9, 1'b1, 1'b1);
        rst = 1'b0;
        checkOutput("mid_rst_cnt",       64'(cnt4), 64'd0);
        checkOutput("mid_rst_out_valid", 64'(ov4),  64'd0);
        checkOutput("mid_rst_D",         64'(d4),   64'd0);
        checkOutput("mid_rst_in_ready",  64'(ir4),  64'd1);
        applyStimulus(0, 4'd4, 1'b1, 1'b1);
        applyStimulus(0, 4'd4, 1'b1, 1'b1);
        applyStimulus(0, 4'd4, 1'b1, 1'b1);
        checkOutput("f4_not_yet_valid", 64'(ov4), 64'd0);
        applyStimulus(0, 4'd4, 1'b1, 1'b1);
        checkOutput("f4_out_valid", 64'(ov4), 64'd1);
        checkOutput("f4_D", 64'(d4), 64'({10'h010, 10'h010, 10'h010, 10'h010}));
        checkOutput("f4_dig_err", 64'(e4), 64'd0);
        checkOutput("f4_err_count", 64'(cnt4), 64'd0);
        applyStimulus(0, 4'd0, 1'b0, 1'b1);

        // Saturating counter with CNT_W=2
        applyStimulus(1, 4'd10, 1'b1, 1'b1);
        checkOutput("sat_1", 64'(cntc), 64'd1);
        applyStimulus(1, 4'd11, 1'b1, 1'b1);
        checkOutput("sat_2", 64'(cntc), 64'd2);
        applyStimulus(1, 4'd12, 1'b1, 1'b1);
        checkOutput("sat_3", 64'(cntc), 64'd3);
        applyStimulus(1, 4'd13, 1'b1, 1'b1);
        checkOutput("sat_4", 64'(cntc), 64'd3);
        checkOutput("sat_frame_err", 64'(ec), 64'b1111);
        applyStimulus(1, 4'd14, 1'b1, 1'b1);
        checkOutput("sat_5", 64'(cntc), 64'd3);

        // DIGITS=1: back-to-back frames, out_valid stays high
        for (int n = 0; n < 10; n++) begin
            applyStimulus(2, 4'(n), 1'b1, 1'b1);
            checkOutput("d1_out_valid", 64'(ov1), 64'd1);
            checkOutput("d1_D", 64'(d1), 64'(10'd1 << n));
            checkOutput("d1_in_ready", 64'(ir1), 64'd1);
        end
        applyStimulus(2, 4'd0, 1'b0, 1'b1);
        checkOutput("d1_drained", 64'(ov1), 64'd0);
        checkOutput("d1_D_held",  64'(d1),  64'h200);
        applyStimulus(2, 4'd15, 1'b1, 1'b1);
        checkOutput("d1_err_D",   64'(d1),   64'd0);
        checkOutput("d1_err_bit", 64'(e1),   64'd1);
        checkOutput("d1_err_cnt", 64'(cnt1), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_stream_decoder.md
# bcd_stream_decoder

Sequential BCD-to-one-hot decoder, the receive-side counterpart of the team's 10-line one-hot BCD encoder. It accepts 4-bit BCD digits one per valid/ready handshake and decodes each into a 10-bit one-hot vector. It assembles DIGITS decoded digits into one output frame and presents the frame on a valid/ready output port. Invalid codes (10–15) are flagged per digit and counted. It sits between a digit source (encoder output, UART digit stream, keypad scanner) and display or compare logic that needs one-hot digits.

## Interface
Parameters:
- DIGITS, default 4: digits per output frame; legal range 1..8.
- CNT_W, default 8: width of the invalid-digit counter.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- A  input  4  BCD digit; sampled when in_valid && in_ready.
- in_valid  input  1  A holds a digit.
- in_ready  output  1  block can accept a digit this cycle.
- D  output  10*DIGITS  decoded frame; digit k in D[10k+9:10k]; digit 0 is the first received.
- dig_err  output  DIGITS  bit k = 1 when digit k of the frame was an invalid code.
- out_valid  output  1  D/dig_err hold a complete frame.
- out_ready  input  1  consumer takes the frame.
- err_count  output  CNT_W  saturating count of invalid digits accepted since reset.

## Operation
- Decode of a valid code n (0..9): one-hot with only bit n set; for example, A=4'd7 gives 10'b0010000000.
- Decode of an invalid code (10..15): 10'b0 for that digit, dig_err bit set, err_count += 1 (saturates at 2^CNT_W−1 and holds).
- Internal collect buffer (10*DIGITS + DIGITS bits) plus digit index idx (0..DIGITS−1).
- Each accepted digit is written to buffer slot idx; idx increments.
- On the last digit (idx == DIGITS−1): buffer and that digit transfer to D/dig_err on the same edge; out_valid is set; idx wraps to 0.
- State machine:
  - COLLECT: out_valid=0, in_ready=1.
  - FULL: out_valid=1, in_ready=out_ready.
  - COLLECT → FULL on acceptance of the last digit.
  - FULL → COLLECT on out_ready, unless the same cycle also completes a new frame. That case occurs only when DIGITS=1 and a digit is accepted; the block then stays in FULL with the new frame.
- in_ready = !out_valid || out_ready (combinational from out_ready and state only, never from in_valid).
- While in FULL, a digit accepted in the handshake cycle starts the next frame at slot 0. No bubble is required.
- D and dig_err change only on a frame-completing edge or on reset. They hold the last frame after it is consumed.
- A is ignored when the handshake does not occur.

## Timing
- Reset values: in_ready=1 after reset, out_valid=0, D=0, dig_err=0, err_count=0, idx=0, buffer=0, state COLLECT.
- Latency: last digit accepted at edge t means out_valid=1 and the new D/dig_err are visible right after edge t (1 cycle from sampling).
- Throughput: one digit per cycle sustained with out_ready held high. With DIGITS=4, out_valid pulses for 1 cycle every 4 cycles.
- Backpressure: out_valid && !out_ready stalls the input (in_ready=0). D, dig_err and out_valid must stay stable until the handshake.
- err_count updates on the edge that accepts the invalid digit, independent of frame completion.
- Reset mid-frame: partial digits are discarded with no frame emitted, and err_count is cleared. The first digit after reset lands in slot 0.
- rst asserted together with in_valid: reset wins; the digit is not accepted.

## Test plan
- Reset, then DIGITS=4 stream 1,2,3,4 with out_ready=1 → one cycle after the 4th accept: out_valid=1, D = {10'h010, 10'h008, 10'h004, 10'h002}, dig_err=4'b0000.
- Stream 9,12,0,15 → D digit1 = 0 and digit3 = 0, dig_err=4'b1010, err_count=2.
- Frame complete with out_ready=0 for 5 cycles while in_valid=1 → in_ready=0 throughout; D stable; no digits accepted. Raise out_ready with digit 5 present → frame consumed, 5 lands in slot 0 on the same edge.
- Send 2 digits, assert rst for 1 cycle, send 4,4,4,4 → output frame is all digit 4 (10'h010 each); the pre-reset digits never appear; err_count=0.
- CNT_W=2: feed 5 invalid codes → err_count goes 1, 2, 3, 3, 3.
- DIGITS=1, out_ready=1, continuous digits 0..9 → out_valid held high; D = 1<<n on each cycle following accept of n.
